// File: rtl/led_pkg.sv
// Shared types and default WS2812 timing (100 MHz clock) for the LED frame encoder.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    localparam int DEF_T0H      = 40;
    localparam int DEF_T1H      = 80;
    localparam int DEF_TBIT     = 125;
    localparam int DEF_TRESET   = 5000;
    localparam int BITS_PER_LED = 24;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit pulse generator: captures the colour MSB at the start of each bit and
// shapes the high/low WS2812 waveform, flagging the last cycle of every bit.
module ws2812_bit_timer
    import led_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic run,
    input  logic lastBit,
    input  logic CurrentBit,
    output logic dout,
    output logic bitEnd
);

    localparam int CW = (TBIT > 2) ? $clog2(TBIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);
    localparam logic [CW-1:0] HI_ONE   = CW'(T1H);

    logic [CW-1:0] cyc;
    logic [CW-1:0] nextCyc;
    logic [CW-1:0] hiLen;
    logic          bitQ;
    logic          levelBit;

    // dout is registered, so it is computed from the phase about to be entered;
    // during cyc 0 the bit is not yet in bitQ and comes straight from CurrentBit.
    always_comb begin
        nextCyc  = cyc + CW'(1);
        levelBit = (cyc == '0) ? CurrentBit : bitQ;
        hiLen    = levelBit ? HI_ONE : HI_ZERO;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= '0;
            bitQ   <= 1'b0;
            dout   <= 1'b0;
            bitEnd <= 1'b0;
        end else if (launch) begin
            cyc    <= '0;
            dout   <= 1'b1;
            bitEnd <= 1'b0;
        end else if (run) begin
            if (cyc == CYC_LAST) begin
                cyc    <= '0;
                dout   <= ~lastBit;
                bitEnd <= 1'b0;
            end else begin
                if (cyc == '0) begin
                    bitQ <= CurrentBit;
                end
                cyc    <= nextCyc;
                dout   <= (nextCyc < hiLen);
                bitEnd <= (nextCyc == CYC_LAST);
            end
        end else begin
            cyc    <= '0;
            dout   <= 1'b0;
            bitEnd <= 1'b0;
        end
    end

endmodule

// File: rtl/ws2812_frame_encoder.sv
// WS2812 frame encoder: streams NUM_LEDS x 24 bits from the upstream GRB shift
// register onto the one-wire line, then holds the line low for the latch gap.
module ws2812_frame_encoder
    import led_pkg::*;
#(
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int NUM_LEDS = 8,
    parameter int TRESET   = DEF_TRESET
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic CurrentBit,
    output logic RotateRegisterLeft,
    output logic dout,
    output logic busy,
    output logic done
);

    localparam int BW      = $clog2(BITS_PER_LED);
    localparam int LW      = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
    localparam int TW      = (TRESET > 2) ? $clog2(TRESET) : 1;
    localparam int DONE_AT = (TRESET > 1) ? TRESET - 2 : 0;

    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_LED - 1);
    localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(TRESET - 1);
    localparam logic [TW-1:0] DONE_CYC   = TW'(DONE_AT);

    state_t        state;
    logic [BW-1:0] bitn;
    logic [LW-1:0] led;
    logic [TW-1:0] latchCyc;
    logic          launch;
    logic          running;
    logic          lastBit;
    logic          bitEnd;

    always_comb begin
        launch  = (state == IDLE) && start;
        running = (state == SEND);
        lastBit = (bitn == BIT_LAST) && (led == LED_LAST);
    end

    ws2812_bit_timer #(
        .T0H (T0H),
        .T1H (T1H),
        .TBIT(TBIT)
    ) bitTimer (
        .clk       (clk),
        .reset     (reset),
        .launch    (launch),
        .run       (running),
        .lastBit   (lastBit),
        .CurrentBit(CurrentBit),
        .dout      (dout),
        .bitEnd    (bitEnd)
    );

    // The end-of-bit strobe is already registered and only ever high in SEND,
    // so it serves directly as the shift-register advance pulse.
    assign RotateRegisterLeft = bitEnd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitn     <= '0;
            led      <= '0;
            latchCyc <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SEND;
                        bitn  <= '0;
                        led   <= '0;
                        busy  <= 1'b1;
                    end
                end

                SEND: begin
                    if (bitEnd) begin
                        if (lastBit) begin
                            state    <= LATCH;
                            latchCyc <= '0;
                            bitn     <= '0;
                            led      <= '0;
                            done     <= (TRESET == 1);
                        end else if (bitn == BIT_LAST) begin
                            bitn <= '0;
                            led  <= led + LW'(1);
                        end else begin
                            bitn <= bitn + BW'(1);
                        end
                    end
                end

                LATCH: begin
                    if (latchCyc == LATCH_LAST) begin
                        state    <= IDLE;
                        latchCyc <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        latchCyc <= latchCyc + TW'(1);
                        done     <= (latchCyc == DONE_CYC);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_encoder.sv
// Directed bench for ws2812_frame_encoder with a small upstream rotate-register model.
module tb_ws2812_frame_encoder;

    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int NL   = 2;
    localparam int TR   = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        CurrentBit;
    logic        RotateRegisterLeft;
    logic        dout;
    logic        busy;
    logic        done;

    logic [23:0] shreg = '0;
    logic [23:0] loadVal = '0;
    logic        loadReq = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Upstream GRB register: loaded by the bench, rotated by the DUT.
    always @(posedge clk) begin
        if (loadReq)
            shreg <= loadVal;
        else if (RotateRegisterLeft)
            shreg <= {shreg[22:0], shreg[23]};
    end
    assign CurrentBit = shreg[23];

    ws2812_frame_encoder #(
        .T0H     (T0H),
        .T1H     (T1H),
        .TBIT    (TBIT),
        .NUM_LEDS(NL),
        .TRESET  (TR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .CurrentBit        (CurrentBit),
        .RotateRegisterLeft(RotateRegisterLeft),
        .dout              (dout),
        .busy              (busy),
        .done              (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [23:0] p);
        loadVal = p;
        loadReq = 1'b1;
        tick();
        loadReq = 1'b0;
    endtask

    // Sends one frame starting in the current cycle and checks every cycle of it.
    // glitch pulses start at frame cycles 5, 100 and the done cycle.
    task automatic run_frame(input logic [23:0] pat, input bit glitch, input string name);
        int   rots;
        int   i;
        logic b;
        logic expD;
        rots = 0;
        i = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int l = 0; l < NL; l++) begin
            for (int bi = 0; bi < 24; bi++) begin
                b = pat[23 - bi];
                for (int k = 0; k < TBIT; k++) begin
                    expD = (k < (b ? T1H : T0H));
                    checks++;
                    if (dout !== expD) begin
                        failures++;
                        $display("FAIL %s_dout led=%0d bit=%0d cyc=%0d got=%b exp=%b", name, l, bi, k, dout, expD);
                    end
                    checks++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_send_status led=%0d bit=%0d cyc=%0d busy=%b done=%b exp busy=1 done=0", name, l, bi, k, busy, done);
                    end
                    checks++;
                    if (RotateRegisterLeft !== (k == TBIT - 1)) begin
                        failures++;
                        $display("FAIL %s_rotate led=%0d bit=%0d cyc=%0d got=%b exp=%b", name, l, bi, k, RotateRegisterLeft, (k == TBIT - 1));
                    end
                    if (RotateRegisterLeft === 1'b1) rots++;
                    start = glitch && (i == 5 || i == 100);
                    i++;
                    tick();
                end
            end
        end
        for (int k = 0; k < TR; k++) begin
            checks++;
            if (dout !== 1'b0 || busy !== 1'b1 || RotateRegisterLeft !== 1'b0 || done !== (k == TR - 1)) begin
                failures++;
                $display("FAIL %s_latch cyc=%0d dout=%b busy=%b rot=%b done=%b exp dout=0 busy=1 rot=0 done=%b", name, k, dout, busy, RotateRegisterLeft, done, (k == TR - 1));
            end
            start = glitch && (k == TR - 1);
            i++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (rots != 24 * NL) begin
            failures++;
            $display("FAIL %s_rotate_count got=%0d exp=%0d", name, rots, 24 * NL);
        end
        checks++;
        if (shreg !== pat) begin
            failures++;
            $display("FAIL %s_register_realigned got=%h exp=%h", name, shreg, pat);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_done busy=%b done=%b dout=%b exp all 0", name, busy, done, dout);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || RotateRegisterLeft !== 1'b0) begin
            failures++;
            $display("FAIL reset_values dout=%b busy=%b done=%b rot=%b exp all 0", dout, busy, done, RotateRegisterLeft);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || RotateRegisterLeft !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_start cyc=%0d dout=%b busy=%b done=%b rot=%b exp all 0", i, dout, busy, done, RotateRegisterLeft);
            end
            tick();
        end
    endtask

    task automatic test_green;
        load_pattern(24'hF00000);
        run_frame(24'hF00000, 1'b0, "green");
    endtask

    task automatic test_clear;
        load_pattern(24'h000000);
        run_frame(24'h000000, 1'b0, "clear");
    endtask

    task automatic test_back_to_back;
        load_pattern(24'hA53C81);
        run_frame(24'hA53C81, 1'b1, "ignored_start");
        run_frame(24'hA53C81, 1'b0, "back_to_back");
        tick();
    endtask

    task automatic test_reset_midframe;
        load_pattern(24'hF00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10 * TBIT + 1) tick();
        // LED 0, bit 10 (a '0'), cycle 1: line still high
        checks++;
        if (dout !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_before_reset dout=%b busy=%b exp dout=1 busy=1", dout, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dout !== 1'b0 || busy !== 1'b0 || RotateRegisterLeft !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midframe_async_reset dout=%b busy=%b rot=%b done=%b exp all 0", dout, busy, RotateRegisterLeft, done);
        end
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) begin
                failures++;
                $display("FAIL midframe_no_done cyc=%0d done=%b busy=%b dout=%b exp all 0", i, done, busy, dout);
            end
            tick();
        end
        load_pattern(24'hF00000);
        run_frame(24'hF00000, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_green();
        test_clear();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
